// File: rtl/alu_op_sequencer.sv
// Handshaked operand source for the 2-bit-select ALU: latches A/B, walks sel 00..11,
// captures aluo after each hold window. Optional checksum output under ALU_OP_SEQ_CHECKSUM_EN.
module alu_op_sequencer #(
  parameter int WIDTH       = 4,
  parameter int HOLD_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [1:0]       sel,
  input  logic [WIDTH:0]   aluo,
  output logic             res_valid,
  output logic [1:0]       res_sel,
  output logic [WIDTH:0]   res_data,
  output logic             busy,
`ifdef ALU_OP_SEQ_CHECKSUM_EN
  output logic [WIDTH:0]   checksum,
`endif
  output logic             done
);

  localparam logic [7:0] CNT_MAX = 8'(HOLD_CYCLES - 1);

  typedef enum logic {IDLE, DRIVE} state_t;

  state_t     state, state_nxt;
  logic [7:0] cnt;
  logic       accept, capture, last;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !rst;
        accept   = in_valid && !rst;
        if (accept) state_nxt = DRIVE;
      end
      DRIVE: begin
        capture = (cnt == CNT_MAX);
        last    = capture && (sel == 2'b11);
        if (last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == DRIVE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      A         <= '0;
      B         <= '0;
      sel       <= 2'b00;
      cnt       <= '0;
      res_data  <= '0;
      res_sel   <= 2'b00;
      res_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      res_valid <= capture;
      done      <= last;
      if (accept) begin
        A   <= in_a;
        B   <= in_b;
        sel <= 2'b00;
        cnt <= '0;
      end else if (capture) begin
        res_data <= aluo;
        res_sel  <= sel;
        cnt      <= '0;
        // sel parks at 11 after the last capture until the next pair arrives
        if (!last) sel <= sel + 2'd1;
      end else if (busy) begin
        cnt <= cnt + 8'd1;
      end
    end
  end

`ifdef ALU_OP_SEQ_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst)          checksum <= '0;
    else if (accept)  checksum <= '0;
    else if (capture) checksum <= checksum ^ aluo;
  end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: HOLD_CYCLES=4 and HOLD_CYCLES=1 instances with an A+B+sel ALU stub,
// table-driven pairs plus hand sequences, results checked against a timed scoreboard.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       iv0, iv1, ir0, ir1;
  logic [3:0] ia, ib;
  logic [3:0] a0, b0, a1, b1;
  logic [1:0] s0, s1, rs0, rs1;
  logic [4:0] al0, al1, rd0, rd1, cs0, cs1;
  logic       rv0, rv1, bz0, bz1, dn0, dn1;
  int         cyc = 0;
  int         nvec = 0;
  int         nerr = 0;

  typedef struct {
    logic [4:0] data;
    logic [1:0] sel;
    int         due;
    bit         last;
    logic [4:0] cs;
  } ent_t;

  typedef struct {
    logic [3:0]      a;
    logic [3:0]      b;
    logic [3:0][4:0] e;
  } vec_t;

  ent_t q0[$];
  ent_t q1[$];
  vec_t tbl[4];
  vec_t vb;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign al0 = {1'b0, a0} + {1'b0, b0} + {3'b000, s0};
  assign al1 = {1'b0, a1} + {1'b0, b1} + {3'b000, s1};

  alu_op_sequencer #(.WIDTH(4), .HOLD_CYCLES(4)) dut0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .in_a(ia), .in_b(ib),
    .A(a0), .B(b0), .sel(s0), .aluo(al0), .res_valid(rv0), .res_sel(rs0),
    .res_data(rd0), .busy(bz0),
`ifdef ALU_OP_SEQ_CHECKSUM_EN
    .checksum(cs0),
`endif
    .done(dn0)
  );

  alu_op_sequencer #(.WIDTH(4), .HOLD_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .in_a(ia), .in_b(ib),
    .A(a1), .B(b1), .sel(s1), .aluo(al1), .res_valid(rv1), .res_sel(rs1),
    .res_data(rd1), .busy(bz1),
`ifdef ALU_OP_SEQ_CHECKSUM_EN
    .checksum(cs1),
`endif
    .done(dn1)
  );

`ifndef ALU_OP_SEQ_CHECKSUM_EN
  assign cs0 = '0;
  assign cs1 = '0;
`endif

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] a, input logic [3:0] b,
                              input logic [4:0] r0, input logic [4:0] r1,
                              input logic [4:0] r2, input logic [4:0] r3);
    vec_t v;
    v.a = a; v.b = b;
    v.e[0] = r0; v.e[1] = r1; v.e[2] = r2; v.e[3] = r3;
    return v;
  endfunction

  task automatic mon(input int d, input logic rv, input logic dn, input logic [4:0] rd,
                     input logic [1:0] rs, input logic [4:0] cs);
    ent_t en;
    int   n;
    n = (d == 0) ? q0.size() : q1.size();
    if (rv || dn) begin
      if (n == 0) begin
        nvec++; nerr++;
        $display("FAIL spurious_strobe dut%0d: res_valid=%0b done=%0b expected none (cycle %0d)",
                 d, rv, dn, cyc);
      end else begin
        if (d == 0) en = q0.pop_front();
        else        en = q1.pop_front();
        chk($sformatf("res_data dut%0d", d), int'(rd), int'(en.data));
        chk($sformatf("res_sel dut%0d", d), int'(rs), int'(en.sel));
        chk($sformatf("capture_cycle dut%0d", d), cyc, en.due);
        chk($sformatf("res_valid dut%0d", d), int'(rv), 1);
        chk($sformatf("done dut%0d", d), int'(dn), int'(en.last));
`ifdef ALU_OP_SEQ_CHECKSUM_EN
        if (en.last) chk($sformatf("checksum dut%0d", d), int'(cs), int'(en.cs));
`else
        if (cs != 5'd0) chk($sformatf("checksum_tie dut%0d", d), int'(cs), 0);
`endif
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, rv0, dn0, rd0, rs0, cs0);
    mon(1, rv1, dn1, rd1, rs1, cs1);
  end

  task automatic offer(input int d, input vec_t v, input bit drop, output int acc);
    int         h, t;
    ent_t       en;
    logic [4:0] x;
    h = (d == 0) ? 4 : 1;
    ia = v.a; ib = v.b;
    if (d == 0) iv0 = 1'b1; else iv1 = 1'b1;
    t = 0; acc = -1;
    while ((((d == 0) ? ir0 : ir1) !== 1'b1) && t < 60) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 60) begin
      nvec++; nerr++;
      $display("FAIL accept_timeout dut%0d: in_ready never high within %0d cycles", d, t);
    end else begin
      acc = cyc + 1;
      x = '0;
      for (int k = 0; k < 4; k++) begin
        x       = x ^ v.e[k];
        en.data = v.e[k];
        en.sel  = 2'(k);
        en.due  = acc + (k + 1) * h;
        en.last = (k == 3);
        en.cs   = x;
        if (d == 0) q0.push_back(en); else q1.push_back(en);
      end
    end
    @(posedge clk); #1;
    if (drop) begin iv0 = 1'b0; iv1 = 1'b0; end
  endtask

  task automatic wait_empty(input int d);
    int t;
    t = 0;
    while (((d == 0) ? q0.size() : q1.size()) != 0 && t < 200) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 200) begin
      nvec++; nerr++;
      $display("FAIL result_timeout dut%0d: %0d results outstanding, expected 0", d,
               (d == 0) ? q0.size() : q1.size());
      if (d == 0) q0.delete(); else q1.delete();
    end
  endtask

  task automatic chk_rst0();
    chk("rst A", int'(a0), 0);
    chk("rst B", int'(b0), 0);
    chk("rst sel", int'(s0), 0);
    chk("rst res_data", int'(rd0), 0);
    chk("rst res_sel", int'(rs0), 0);
    chk("rst res_valid", int'(rv0), 0);
    chk("rst done", int'(dn0), 0);
    chk("rst busy", int'(bz0), 0);
`ifdef ALU_OP_SEQ_CHECKSUM_EN
    chk("rst checksum", int'(cs0), 0);
`endif
  endtask

  initial begin
    int acc, acc2, t, strobes;
    tbl[0] = mk(4'd7,  4'd8,  5'd15, 5'd16, 5'd17, 5'd18);
    tbl[1] = mk(4'd15, 4'd15, 5'd30, 5'd31, 5'd0,  5'd1);
    tbl[2] = mk(4'd0,  4'd0,  5'd0,  5'd1,  5'd2,  5'd3);
    tbl[3] = mk(4'd10, 4'd13, 5'd23, 5'd24, 5'd25, 5'd26);
    vb     = mk(4'd1,  4'd2,  5'd3,  5'd4,  5'd5,  5'd6);

    rst = 1'b1; iv0 = 1'b0; iv1 = 1'b0; ia = '0; ib = '0;
    @(posedge clk); #1;
    chk("in_ready during rst", int'(ir0), 0);
    @(posedge clk); #1;
    chk_rst0();
    rst = 1'b0; #1;
    chk("in_ready after rst", int'(ir0), 1);
    @(posedge clk); #1;

    // busy rejection: a new pair offered mid-sequence must not disturb A/B
    offer(0, tbl[0], 1'b1, acc);
    ia = 4'd3; ib = 4'd4; iv0 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("busy in_ready", int'(ir0), 0);
      chk("busy A hold", int'(a0), 7);
      chk("busy B hold", int'(b0), 8);
      @(posedge clk); #1;
    end
    iv0 = 1'b0;
    wait_empty(0);
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) begin
      offer(0, tbl[i], 1'b1, acc);
      wait_empty(0);
      @(posedge clk); #1;
      chk("idle sel parked", int'(s0), 3);
      chk("idle busy", int'(bz0), 0);
      chk("idle in_ready", int'(ir0), 1);
    end

    // back-to-back: in_valid held through the done cycle
    offer(0, tbl[1], 1'b0, acc);
    offer(0, vb, 1'b1, acc2);
    chk("b2b A", int'(a0), 1);
    chk("b2b B", int'(b0), 2);
    chk("b2b sel", int'(s0), 0);
    chk("b2b accept edge", acc2, acc + 17);
    wait_empty(0);
    @(posedge clk); #1;

    // reset after the second capture
    offer(0, tbl[0], 1'b1, acc);
    t = 0;
    while (q0.size() > 2 && t < 100) begin @(posedge clk); #1; t++; end
    chk("reach second capture", int'(q0.size()), 2);
    rst = 1'b1;
    q0.delete();
    @(posedge clk); #1;
    chk_rst0();
    chk("in_ready in rst", int'(ir0), 0);
    rst = 1'b0; #1;
    chk("in_ready post rst", int'(ir0), 1);
    strobes = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (rv0 || dn0) strobes++;
    end
    chk("no strobes after abort", strobes, 0);

    // HOLD_CYCLES=1: four consecutive captures
    offer(1, tbl[0], 1'b1, acc);
    wait_empty(1);
    @(posedge clk); #1;
    chk("h1 idle busy", int'(bz1), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
